pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed-field inter-stage latch: one pipeline stage register carrying a WIDTH-bit packed payload with a valid/ready handshake in place of a bare load enable.
- An optional two-entry skid buffer lets in_ready be fully registered, breaking the backward stall path between stages.
- Adds a synchronous flush (for branch mispredict or kill) and a saturating back-pressure counter for performance analysis.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB, with the stage fields packed into in_data.

---
 rtl/pipe_stage_skid.sv | 106 ++++++++++
 tb/tb_pipe_stage_skid.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module pipe_stage_skid #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_cnt_clr
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fire, out_fire;

    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = cnt_q;

    // Skid mode registers in_ready so no combinational path runs from out_ready upstream.
    assign in_ready = (SKID != 0) ? ready_q : (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d = StOne;
                    main_d  = in_data;
                end
            end
            StOne: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire && (SKID != 0)) begin
                    state_d = StTwo;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (out_fire) begin
                    state_d = StOne;
                    main_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Payload registers keep their contents on flush; only the state is killed.
        if (flush) begin
            state_d = StEmpty;
        end
        ready_d = (state_d != StTwo);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: skid instance checked through an expected-beat queue,
// plus a small directed check of the combinational-ready variant.
module tb_pipe_stage_skid;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] occupancy;
    logic [2:0] stall_cnt;
    logic       stall_cnt_clr;

    logic       nos_flush;
    logic       nos_in_valid;
    logic       nos_in_ready;
    logic [7:0] nos_in_data;
    logic       nos_out_valid;
    logic       nos_out_ready;
    logic [7:0] nos_out_data;
    logic [1:0] nos_occupancy;
    logic [3:0] nos_stall_cnt;
    logic       nos_stall_cnt_clr;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    pipe_stage_skid #(
        .WIDTH(8),
        .SKID (1),
        .CNT_W(3)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .occupancy    (occupancy),
        .stall_cnt    (stall_cnt),
        .stall_cnt_clr(stall_cnt_clr)
    );

    pipe_stage_skid #(
        .WIDTH(8),
        .SKID (0),
        .CNT_W(4)
    ) u_nos (
        .clk          (clk),
        .rst          (rst),
        .flush        (nos_flush),
        .in_valid     (nos_in_valid),
        .in_ready     (nos_in_ready),
        .in_data      (nos_in_data),
        .out_valid    (nos_out_valid),
        .out_ready    (nos_out_ready),
        .out_data     (nos_out_data),
        .occupancy    (nos_occupancy),
        .stall_cnt    (nos_stall_cnt),
        .stall_cnt_clr(nos_stall_cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Pops on every accepted output beat; also checks data/valid stay put during a stall.
    task automatic monitor();
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (prev_stall && !rst) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready && !rst) begin
                check("sb_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("sb_data", out_data, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready && !flush && !rst;
            prev_data  = out_data;
        end
    endtask

    initial begin
        rst = 1'b1;  flush = 1'b0;  in_valid = 1'b0;  in_data = '0;
        out_ready = 1'b0;  stall_cnt_clr = 1'b0;
        nos_flush = 1'b0;  nos_in_valid = 1'b0;  nos_in_data = '0;
        nos_out_ready = 1'b0;  nos_stall_cnt_clr = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_out_data", out_data, 0);

        // Streaming at one beat per cycle
        next();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            @(negedge clk);
            check("stream_in_ready", in_ready, 1);
            check("stream_occ_le1", occupancy <= 2'd1, 1);
            if (i > 1) begin
                check("stream_valid", out_valid, 1);
                check("stream_latency", out_data, i - 1);
            end
            exp_q.push_back(8'(i));
            next();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last", out_data, 8'h10);
        check("stream_stall_cnt", stall_cnt, 0);
        next();
        out_ready = 1'b0;

        // Back-pressure fills the skid entry
        in_valid = 1'b1;
        in_data  = 8'h0A;
        @(negedge clk);
        check("bp_ready_a", in_ready, 1);
        exp_q.push_back(8'h0A);
        next();
        in_data = 8'h0B;
        @(negedge clk);
        check("bp_ready_b", in_ready, 1);
        check("bp_occ_1", occupancy, 1);
        exp_q.push_back(8'h0B);
        next();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_occ_2", occupancy, 2);
        check("bp_ready_full", in_ready, 0);
        check("bp_head", out_data, 8'h0A);
        check("bp_cnt_1", stall_cnt, 1);
        next();
        next();
        @(negedge clk);
        check("bp_cnt_3", stall_cnt, 3);
        check("bp_head_held", out_data, 8'h0A);
        next();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_still0", in_ready, 0);
        next();
        @(negedge clk);
        check("bp_ready_back", in_ready, 1);
        check("bp_second", out_data, 8'h0B);
        check("bp_occ_after", occupancy, 1);
        next();
        @(negedge clk);
        check("bp_empty", out_valid, 0);
        check("bp_cnt_hold", stall_cnt, 4);

        // Saturating stall counter and clear priority
        next();
        out_ready = 1'b0;
        stall_cnt_clr = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h0E;
        @(negedge clk);
        exp_q.push_back(8'h0E);
        next();
        stall_cnt_clr = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("cnt_cleared", stall_cnt, 0);
        repeat (10) next();
        @(negedge clk);
        check("cnt_saturated", stall_cnt, 7);
        next();
        stall_cnt_clr = 1'b1;
        @(negedge clk);
        check("cnt_still_sat", stall_cnt, 7);
        next();
        stall_cnt_clr = 1'b0;
        @(negedge clk);
        check("cnt_clr_wins", stall_cnt, 0);
        next();
        @(negedge clk);
        check("cnt_restart", stall_cnt, 1);
        next();
        out_ready = 1'b1;
        next();

        // Flush from full, then a beat accepted during flush is dropped
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h11;
        @(negedge clk);
        exp_q.push_back(8'h11);
        next();
        in_data = 8'h12;
        @(negedge clk);
        exp_q.push_back(8'h12);
        next();
        flush = 1'b1;
        in_data = 8'h0C;
        @(negedge clk);
        check("fl_occ_before", occupancy, 2);
        next();
        exp_q.delete();
        @(negedge clk);
        check("fl_valid", out_valid, 0);
        check("fl_occ", occupancy, 0);
        check("fl_ready", in_ready, 1);
        next();
        flush = 1'b0;
        in_data = 8'h0D;
        out_ready = 1'b1;
        @(negedge clk);
        check("fl_dropped", out_valid, 0);
        check("fl_ready_d", in_ready, 1);
        exp_q.push_back(8'h0D);
        next();
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_d_valid", out_valid, 1);
        check("fl_d_data", out_data, 8'h0D);
        next();

        // Asynchronous reset while full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h21;
        @(negedge clk);
        exp_q.push_back(8'h21);
        next();
        in_data = 8'h22;
        @(negedge clk);
        exp_q.push_back(8'h22);
        next();
        in_valid = 1'b0;
        @(negedge clk);
        check("ar_occ_before", occupancy, 2);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_occ", occupancy, 0);
        check("ar_data", out_data, 0);
        check("ar_ready", in_ready, 1);
        check("ar_cnt", stall_cnt, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h33;
        out_ready = 1'b1;
        @(negedge clk);
        check("ar_ready_after", in_ready, 1);
        exp_q.push_back(8'h33);
        next();
        in_valid = 1'b0;
        @(negedge clk);
        check("ar_first_valid", out_valid, 1);
        check("ar_first_data", out_data, 8'h33);
        next();

        // Single-register variant: combinational in_ready
        nos_in_valid = 1'b1;
        nos_in_data = 8'h0A;
        @(negedge clk);
        check("nos_ready_empty", nos_in_ready, 1);
        next();
        nos_in_data = 8'h0B;
        @(negedge clk);
        check("nos_ready_full", nos_in_ready, 0);
        check("nos_occ", nos_occupancy, 1);
        check("nos_head", nos_out_data, 8'h0A);
        #1 nos_out_ready = 1'b1;
        #1;
        check("nos_ready_comb", nos_in_ready, 1);
        next();
        nos_in_valid = 1'b0;
        @(negedge clk);
        check("nos_valid_b", nos_out_valid, 1);
        check("nos_data_b", nos_out_data, 8'h0B);
        next();
        @(negedge clk);
        check("nos_drained", nos_out_valid, 0);
        check("nos_ready_idle", nos_in_ready, 1);

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
